// File: rtl/controlador_encoder_if.sv
// Requester handshake and encoder-side bus of the 8b/10b link sequencer.
interface controlador_encoder_if;
  logic       reqA;
  logic [7:0] datoA;
  logic       ultimoA;
  logic       listoA;
  logic       reqB;
  logic [7:0] datoB;
  logic       ultimoB;
  logic       listoB;
  logic [7:0] entradas;
  logic       K;
  logic       enb;
  logic       concesion;
  logic       ocupado;
  logic       errorLargo;

  modport master (
    output reqA, datoA, ultimoA, reqB, datoB, ultimoB,
    input  listoA, listoB, entradas, K, enb, concesion, ocupado, errorLargo
  );

  modport slave (
    input  reqA, datoA, ultimoA, reqB, datoB, ultimoB,
    output listoA, listoB, entradas, K, enb, concesion, ocupado, errorLargo
  );
endinterface

// File: rtl/controlador_encoder.sv
// Link-layer sequencer feeding an 8b/10b encoder: comma burst, idle, and
// round-robin framing of two byte-stream requesters with SOF/EOF symbols.
module controlador_encoder #(
  parameter int unsigned N_COMAS   = 4,
  parameter int unsigned LARGO_MAX = 16,
  parameter logic [7:0]  SIMB_IDLE = 8'hBC,
  parameter logic [7:0]  SIMB_SOF  = 8'hFB,
  parameter logic [7:0]  SIMB_EOF  = 8'hFD
) (
  input logic                   clk,
  input logic                   rst,
  controlador_encoder_if.slave  bus
);

  localparam int unsigned       CW         = $clog2(LARGO_MAX + 1);
  localparam logic [CW-1:0]     CUENTA_MAX = CW'(LARGO_MAX);
  localparam logic [3:0]        ULT_COMA   = 4'(N_COMAS - 1);

  typedef enum logic [2:0] {ALINEAR, REPOSO, INICIO, DATOS, FIN} estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    comas_q, comas_d;
  logic [CW-1:0] cuenta_q, cuenta_d;
  logic          rr_q, rr_d;
  logic          forzado_q, forzado_d;
  logic [7:0]    entradas_q, entradas_d;
  logic          k_q, k_d;
  logic          enb_q, enb_d;
  logic          concesion_q, concesion_d;
  logic          ocupado_q, ocupado_d;
  logic          error_q, error_d;

  logic          listo_a, listo_b;
  logic          sel_req, sel_ultimo;
  logic [7:0]    sel_dato;
  logic          xfer;

  assign listo_a    = (estado_q == DATOS) && !concesion_q;
  assign listo_b    = (estado_q == DATOS) &&  concesion_q;
  assign sel_req    = concesion_q ? bus.reqB    : bus.reqA;
  assign sel_dato   = concesion_q ? bus.datoB   : bus.datoA;
  assign sel_ultimo = concesion_q ? bus.ultimoB : bus.ultimoA;
  assign xfer       = (estado_q == DATOS) && sel_req;

  always_comb begin
    estado_d    = estado_q;
    comas_d     = comas_q;
    cuenta_d    = cuenta_q;
    rr_d        = rr_q;
    forzado_d   = forzado_q;
    entradas_d  = SIMB_IDLE;
    k_d         = 1'b1;
    enb_d       = 1'b1;
    concesion_d = concesion_q;
    ocupado_d   = ocupado_q;
    error_d     = 1'b0;

    case (estado_q)
      ALINEAR: begin
        ocupado_d = 1'b0;
        if (comas_q == ULT_COMA) begin
          comas_d  = '0;
          estado_d = REPOSO;
        end else begin
          comas_d  = comas_q + 4'd1;
        end
      end
      REPOSO: begin
        ocupado_d = 1'b0;
        // B wins only when A is absent or the pointer favours B.
        if (bus.reqA && (!bus.reqB || !rr_q)) begin
          concesion_d = 1'b0;
          estado_d    = INICIO;
        end else if (bus.reqB) begin
          concesion_d = 1'b1;
          estado_d    = INICIO;
        end
      end
      INICIO: begin
        entradas_d = SIMB_SOF;
        ocupado_d  = 1'b1;
        estado_d   = DATOS;
      end
      DATOS: begin
        if (xfer) begin
          entradas_d = sel_dato;
          k_d        = 1'b0;
          cuenta_d   = cuenta_q + CW'(1);
          if (sel_ultimo) begin
            estado_d = FIN;
          end else if (cuenta_d == CUENTA_MAX) begin
            forzado_d = 1'b1;
            estado_d  = FIN;
          end
        end
      end
      FIN: begin
        entradas_d = SIMB_EOF;
        error_d    = forzado_q;
        forzado_d  = 1'b0;
        rr_d       = ~concesion_q;
        cuenta_d   = '0;
        estado_d   = REPOSO;
      end
      default: estado_d = ALINEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q    <= ALINEAR;
      comas_q     <= '0;
      cuenta_q    <= '0;
      rr_q        <= 1'b0;
      forzado_q   <= 1'b0;
      entradas_q  <= '0;
      k_q         <= 1'b0;
      enb_q       <= 1'b0;
      concesion_q <= 1'b0;
      ocupado_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      comas_q     <= comas_d;
      cuenta_q    <= cuenta_d;
      rr_q        <= rr_d;
      forzado_q   <= forzado_d;
      entradas_q  <= entradas_d;
      k_q         <= k_d;
      enb_q       <= enb_d;
      concesion_q <= concesion_d;
      ocupado_q   <= ocupado_d;
      error_q     <= error_d;
    end
  end

  assign bus.listoA     = listo_a;
  assign bus.listoB     = listo_b;
  assign bus.entradas   = entradas_q;
  assign bus.K          = k_q;
  assign bus.enb        = enb_q;
  assign bus.concesion  = concesion_q;
  assign bus.ocupado    = ocupado_q;
  assign bus.errorLargo = error_q;

endmodule

// File: tb/tb_controlador_encoder.sv
// Directed bench for controlador_encoder: two instances (LARGO_MAX 16 and 4).
module tb_controlador_encoder;

  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  // Per-cycle row: inputs applied before the edge, outputs expected after it.
  typedef struct packed {
    logic       ra;
    logic       ua;
    logic [7:0] da;
    logic       rb;
    logic       ub;
    logic [7:0] db;
    logic [7:0] sym;
    logic       k;
    logic       ocu;
    logic       la;
    logic       lb;
    logic       conc;
    logic       err;
  } row_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  controlador_encoder_if i0 ();
  controlador_encoder_if i1 ();

  controlador_encoder #(.N_COMAS(4), .LARGO_MAX(16)) dut0 (.clk(clk), .rst(rst), .bus(i0));
  controlador_encoder #(.N_COMAS(4), .LARGO_MAX(4))  dut1 (.clk(clk), .rst(rst), .bus(i1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {entradas, K, ocupado, listoA, listoB, concesion, errorLargo, enb}
  function automatic logic [14:0] obs0();
    return {i0.entradas, i0.K, i0.ocupado, i0.listoA, i0.listoB, i0.concesion, i0.errorLargo, i0.enb};
  endfunction

  function automatic logic [14:0] obs1();
    return {i1.entradas, i1.K, i1.ocupado, i1.listoA, i1.listoB, i1.concesion, i1.errorLargo, i1.enb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i0.reqA = 1'b0; i0.ultimoA = 1'b0; i0.datoA = 8'h00;
    i0.reqB = 1'b0; i0.ultimoB = 1'b0; i0.datoB = 8'h00;
    i1.reqA = 1'b0; i1.ultimoA = 1'b0; i1.datoA = 8'h00;
    i1.reqB = 1'b0; i1.ultimoB = 1'b0; i1.datoB = 8'h00;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    idle_inputs();
    rst = 1'b0;
    #3;
    n_cmp++;
    if (obs0() !== 15'h0000) begin
      n_bad++;
      $display("FAIL reset_dut0: got %h want %h", obs0(), 15'h0000);
    end
    n_cmp++;
    if (obs1() !== 15'h0000) begin
      n_bad++;
      $display("FAIL reset_dut1: got %h want %h", obs1(), 15'h0000);
    end
    @(negedge clk);
    rst = 1'b1;
    exp = {8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (obs0() !== exp) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, obs0(), exp);
      end
    end
  endtask

  task automatic test_frame_a();
    row_t rows [7];
    rows = '{
      '{I,O,8'h01,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,O,8'h01,O,O,8'h00, 8'hFB,I,I,I,O,O,O},
      '{I,O,8'h01,O,O,8'h00, 8'h01,O,I,I,O,O,O},
      '{I,O,8'h02,O,O,8'h00, 8'h02,O,I,I,O,O,O},
      '{I,I,8'h03,O,O,8'h00, 8'h03,O,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hFD,I,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hBC,I,O,O,O,O,O}
    };
    for (int i = 0; i < 7; i++) begin
      i0.reqA = rows[i].ra; i0.ultimoA = rows[i].ua; i0.datoA = rows[i].da;
      i0.reqB = rows[i].rb; i0.ultimoB = rows[i].ub; i0.datoB = rows[i].db;
      tick();
      n_cmp++;
      if (obs0() !== {rows[i].sym, rows[i].k, rows[i].ocu, rows[i].la, rows[i].lb, rows[i].conc, rows[i].err, 1'b1}) begin
        n_bad++;
        $display("FAIL frame_a[%0d]: got %h want %h", i, obs0(),
                 {rows[i].sym, rows[i].k, rows[i].ocu, rows[i].la, rows[i].lb, rows[i].conc, rows[i].err, 1'b1});
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows [13];
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();
    rows = '{
      '{I,I,8'hAA,I,I,8'hBB, 8'hBC,I,O,O,O,O,O},
      '{I,I,8'hAA,I,I,8'hBB, 8'hFB,I,I,I,O,O,O},
      '{I,I,8'hAA,I,I,8'hBB, 8'hAA,O,I,O,O,O,O},
      '{I,I,8'hA2,I,I,8'hBB, 8'hFD,I,I,O,O,O,O},
      '{I,I,8'hA2,I,I,8'hBB, 8'hBC,I,O,O,O,I,O},
      '{I,I,8'hA2,I,I,8'hBB, 8'hFB,I,I,O,I,I,O},
      '{I,I,8'hA2,I,I,8'hBB, 8'hBB,O,I,O,O,I,O},
      '{I,I,8'hA2,I,I,8'hB2, 8'hFD,I,I,O,O,I,O},
      '{I,I,8'hA2,I,I,8'hB2, 8'hBC,I,O,O,O,O,O},
      '{I,I,8'hA2,I,I,8'hB2, 8'hFB,I,I,I,O,O,O},
      '{I,I,8'hA2,I,I,8'hB2, 8'hA2,O,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hFD,I,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hBC,I,O,O,O,O,O}
    };
    for (int i = 0; i < 13; i++) begin
      i0.reqA = rows[i].ra; i0.ultimoA = rows[i].ua; i0.datoA = rows[i].da;
      i0.reqB = rows[i].rb; i0.ultimoB = rows[i].ub; i0.datoB = rows[i].db;
      tick();
      n_cmp++;
      if (obs0() !== {rows[i].sym, rows[i].k, rows[i].ocu, rows[i].la, rows[i].lb, rows[i].conc, rows[i].err, 1'b1}) begin
        n_bad++;
        $display("FAIL round_robin[%0d]: got %h want %h", i, obs0(),
                 {rows[i].sym, rows[i].k, rows[i].ocu, rows[i].la, rows[i].lb, rows[i].conc, rows[i].err, 1'b1});
      end
    end
  endtask

  // Run on the LARGO_MAX=4 instance so fill cycles counted as bytes would force an EOF.
  task automatic test_fill();
    row_t rows [9];
    rows = '{
      '{I,O,8'h11,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,O,8'h11,O,O,8'h00, 8'hFB,I,I,I,O,O,O},
      '{I,O,8'h11,O,O,8'h00, 8'h11,O,I,I,O,O,O},
      '{O,O,8'h22,O,O,8'h00, 8'hBC,I,I,I,O,O,O},
      '{O,O,8'h22,O,O,8'h00, 8'hBC,I,I,I,O,O,O},
      '{I,O,8'h22,O,O,8'h00, 8'h22,O,I,I,O,O,O},
      '{I,I,8'h33,O,O,8'h00, 8'h33,O,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hFD,I,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hBC,I,O,O,O,O,O}
    };
    for (int i = 0; i < 9; i++) begin
      i1.reqA = rows[i].ra; i1.ultimoA = rows[i].ua; i1.datoA = rows[i].da;
      i1.reqB = rows[i].rb; i1.ultimoB = rows[i].ub; i1.datoB = rows[i].db;
      tick();
      n_cmp++;
      if (obs1() !== {rows[i].sym, rows[i].k, rows[i].ocu, rows[i].la, rows[i].lb, rows[i].conc, rows[i].err, 1'b1}) begin
        n_bad++;
        $display("FAIL fill[%0d]: got %h want %h", i, obs1(),
                 {rows[i].sym, rows[i].k, rows[i].ocu, rows[i].la, rows[i].lb, rows[i].conc, rows[i].err, 1'b1});
      end
    end
  endtask

  task automatic test_largo_max();
    row_t rows [13];
    rows = '{
      '{I,O,8'h01,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,O,8'h01,O,O,8'h00, 8'hFB,I,I,I,O,O,O},
      '{I,O,8'h01,O,O,8'h00, 8'h01,O,I,I,O,O,O},
      '{I,O,8'h02,O,O,8'h00, 8'h02,O,I,I,O,O,O},
      '{I,O,8'h03,O,O,8'h00, 8'h03,O,I,I,O,O,O},
      '{I,O,8'h04,O,O,8'h00, 8'h04,O,I,O,O,O,O},
      '{I,O,8'h05,O,O,8'h00, 8'hFD,I,I,O,O,O,I},
      '{I,O,8'h05,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,O,8'h05,O,O,8'h00, 8'hFB,I,I,I,O,O,O},
      '{I,O,8'h05,O,O,8'h00, 8'h05,O,I,I,O,O,O},
      '{I,I,8'h06,O,O,8'h00, 8'h06,O,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hFD,I,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hBC,I,O,O,O,O,O}
    };
    for (int i = 0; i < 13; i++) begin
      i1.reqA = rows[i].ra; i1.ultimoA = rows[i].ua; i1.datoA = rows[i].da;
      i1.reqB = rows[i].rb; i1.ultimoB = rows[i].ub; i1.datoB = rows[i].db;
      tick();
      n_cmp++;
      if (obs1() !== {rows[i].sym, rows[i].k, rows[i].ocu, rows[i].la, rows[i].lb, rows[i].conc, rows[i].err, 1'b1}) begin
        n_bad++;
        $display("FAIL largo_max[%0d]: got %h want %h", i, obs1(),
                 {rows[i].sym, rows[i].k, rows[i].ocu, rows[i].la, rows[i].lb, rows[i].conc, rows[i].err, 1'b1});
      end
    end
  endtask

  task automatic test_reset_midframe();
    row_t pre [3];
    row_t post [9];
    pre = '{
      '{I,O,8'h5A,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,O,8'h5A,O,O,8'h00, 8'hFB,I,I,I,O,O,O},
      '{I,O,8'h5A,O,O,8'h00, 8'h5A,O,I,I,O,O,O}
    };
    // Request held through reset: SOF may only follow the full 4-comma burst.
    post = '{
      '{I,I,8'h5A,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,I,8'h5A,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,I,8'h5A,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,I,8'h5A,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,I,8'h5A,O,O,8'h00, 8'hBC,I,O,O,O,O,O},
      '{I,I,8'h5A,O,O,8'h00, 8'hFB,I,I,I,O,O,O},
      '{I,I,8'h5A,O,O,8'h00, 8'h5A,O,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hFD,I,I,O,O,O,O},
      '{O,O,8'h00,O,O,8'h00, 8'hBC,I,O,O,O,O,O}
    };
    for (int i = 0; i < 3; i++) begin
      i0.reqA = pre[i].ra; i0.ultimoA = pre[i].ua; i0.datoA = pre[i].da;
      i0.reqB = pre[i].rb; i0.ultimoB = pre[i].ub; i0.datoB = pre[i].db;
      tick();
      n_cmp++;
      if (obs0() !== {pre[i].sym, pre[i].k, pre[i].ocu, pre[i].la, pre[i].lb, pre[i].conc, pre[i].err, 1'b1}) begin
        n_bad++;
        $display("FAIL midframe_pre[%0d]: got %h want %h", i, obs0(),
                 {pre[i].sym, pre[i].k, pre[i].ocu, pre[i].la, pre[i].lb, pre[i].conc, pre[i].err, 1'b1});
      end
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs0() !== 15'h0000) begin
      n_bad++;
      $display("FAIL midframe_async_reset: got %h want %h", obs0(), 15'h0000);
    end
    i0.ultimoA = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      i0.reqA = post[i].ra; i0.ultimoA = post[i].ua; i0.datoA = post[i].da;
      i0.reqB = post[i].rb; i0.ultimoB = post[i].ub; i0.datoB = post[i].db;
      tick();
      n_cmp++;
      if (obs0() !== {post[i].sym, post[i].k, post[i].ocu, post[i].la, post[i].lb, post[i].conc, post[i].err, 1'b1}) begin
        n_bad++;
        $display("FAIL midframe_post[%0d]: got %h want %h", i, obs0(),
                 {post[i].sym, post[i].k, post[i].ocu, post[i].la, post[i].lb, post[i].conc, post[i].err, 1'b1});
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_frame_a();
    test_round_robin();
    test_fill();
    test_largo_max();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
